// File: rtl/ov5640_init_pkg.sv
// ov5640_init_pkg: shared state encoding, table entry layout and retry limit
package ov5640_init_pkg;
    typedef enum logic [2:0] {IDLE, PWR_WAIT, FETCH, LOAD, ISSUE, WAIT, DONE, FAIL} state_t;
    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int REG_DATA_MSB = 7;
    localparam int REG_DATA_LSB = 0;
    localparam int RETRY_LIMIT  = 3;
endpackage

// File: rtl/ov5640_wait_timer.sv
// ov5640_wait_timer: loadable down-counter; expire is high in the load-th cycle after start
module ov5640_wait_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         expire
);
    logic [W-1:0] cnt;
    logic         run;

    // a load of 0 behaves like 1, so the counter never wraps
    assign expire = run && (cnt <= W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= load;
            run <= 1'b1;
        end else if (expire) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks a register table and issues SCCB writes with power-up/reset waits
// Define OV5640_INIT_RETRY_EN to retry a NACKed entry up to RETRY_LIMIT times before failing.
module ov5640_init_sequencer
    import ov5640_init_pkg::*;
#(
    parameter int TABLE_LEN    = 252,
    parameter int ADDR_WIDTH   = 8,
    parameter int PWR_WAIT_CYC = 1_000_000,
    parameter int RST_WAIT_CYC = 250_000,
    parameter int RST_IDX      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_ack,
    input  logic                  wr_err,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] idx
);
    localparam int MAX_WAIT = (PWR_WAIT_CYC > RST_WAIT_CYC) ? PWR_WAIT_CYC : RST_WAIT_CYC;
    localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t          state;
    logic            go, ack_ok, rst_hit, last, tmr_start, tmr_exp;
    logic [CW-1:0]   tmr_load;
`ifdef OV5640_INIT_RETRY_EN
    logic [1:0]      retry;
`endif

    assign go        = start && (state == IDLE || state == DONE || state == FAIL);
    assign ack_ok    = (state == ISSUE) && wr_ack && !wr_err;
    assign rst_hit   = idx == ADDR_WIDTH'(RST_IDX);
    assign last      = idx == ADDR_WIDTH'(TABLE_LEN - 1);
    assign tmr_start = go || (ack_ok && rst_hit);
    assign tmr_load  = go ? CW'(PWR_WAIT_CYC) : CW'(RST_WAIT_CYC);

    ov5640_wait_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (tmr_start),
        .load   (tmr_load),
        .expire (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            rom_addr <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_req   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
            retry    <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, FAIL: if (go) begin
                    state <= PWR_WAIT;
                    idx   <= '0;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                    err   <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
                    retry <= '0;
`endif
                end
                PWR_WAIT: if (tmr_exp) begin
                    state    <= FETCH;
                    rom_addr <= idx;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    wr_addr <= rom_q[REG_ADDR_MSB:REG_ADDR_LSB];
                    wr_data <= rom_q[REG_DATA_MSB:REG_DATA_LSB];
                    wr_req  <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: if (wr_err) begin
                    wr_req <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
                    if (retry < 2'(RETRY_LIMIT)) begin
                        retry <= retry + 1'b1;
                        state <= FETCH;
                    end else begin
                        state <= FAIL;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
`else
                    state <= FAIL;
                    err   <= 1'b1;
                    busy  <= 1'b0;
`endif
                end else if (wr_ack) begin
                    wr_req <= 1'b0;
`ifdef OV5640_INIT_RETRY_EN
                    retry  <= '0;
`endif
                    if (rst_hit) state <= WAIT;
                    else if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx      <= idx + 1'b1;
                        rom_addr <= idx + 1'b1;
                        state    <= FETCH;
                    end
                end
                WAIT: if (tmr_exp) begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx      <= idx + 1'b1;
                        rom_addr <= idx + 1'b1;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ov5640_init_sequencer.md
OV5640_INIT_SEQUENCER -- requirements
Module: ov5640_init_sequencer

Interface
REQ-001 SHALL have parameter TABLE_LEN, default 252, number of valid table entries (indices 0..TABLE_LEN-1).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, table address width.
REQ-003 SHALL have parameter PWR_WAIT_CYC, default 1_000_000, power-up wait in clk cycles (20 ms at 50 MHz).
REQ-004 SHALL have parameter RST_WAIT_CYC, default 250_000, post-software-reset wait in clk cycles (5 ms at 50 MHz).
REQ-005 SHALL have parameter RST_IDX, default 1, table index followed by the RST_WAIT_CYC wait.
REQ-006 SHALL have ports: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: start  in  1  one-cycle pulse that begins a sequence; rom_addr  out  ADDR_WIDTH  table address; rom_q  in  24  table word {reg_addr[23:8], reg_data[7:0]}, valid 1 cycle after rom_addr.
REQ-008 SHALL have ports: wr_req  out  1  SCCB write request; wr_addr  out  16  register address; wr_data  out  8  register data; wr_ack  in  1  one-cycle write-complete pulse; wr_err  in  1  one-cycle NACK pulse, mutually exclusive with wr_ack.
REQ-009 SHALL have ports: busy  out  1; done  out  1  level, sequence complete; err  out  1  level, sequence aborted; idx  out  ADDR_WIDTH  current entry index.

Function
REQ-010 SHALL implement states IDLE, PWR_WAIT, FETCH, LOAD, ISSUE, WAIT, DONE, FAIL.
REQ-011 IDLE/DONE/FAIL + start -> PWR_WAIT with idx cleared to 0, done and err cleared; start in any other state SHALL be ignored.
REQ-012 PWR_WAIT SHALL count PWR_WAIT_CYC cycles, then go to FETCH.
REQ-013 FETCH SHALL drive rom_addr = idx for one cycle; LOAD SHALL capture rom_q into wr_addr/wr_data on the next cycle; then ISSUE.
REQ-014 ISSUE SHALL hold wr_req = 1 with wr_addr/wr_data stable until wr_ack or wr_err is sampled; wr_req SHALL be 0 in the cycle after the sample.
REQ-015 On wr_ack: if idx == RST_IDX -> WAIT (RST_WAIT_CYC cycles) then advance; else advance immediately.
REQ-016 Advance: idx == TABLE_LEN-1 -> DONE; else idx+1 -> FETCH.
REQ-017 wr_ack and wr_err in the same cycle SHALL be treated as wr_err.
REQ-018 busy SHALL be 1 in PWR_WAIT, FETCH, LOAD, ISSUE and WAIT; 0 otherwise.
REQ-019 In DONE, done = 1; in FAIL, err = 1; idx SHALL hold the failing entry index.
REQ-020 Wait counters SHALL be wide enough for max(PWR_WAIT_CYC, RST_WAIT_CYC) and SHALL not wrap.

Reset
REQ-021 rst_n low SHALL force IDLE; idx, rom_addr, wr_addr, wr_data and counters = 0; wr_req, busy, done and err = 0.
REQ-022 Reset asserted mid-write SHALL drop wr_req asynchronously; no partial state SHALL survive.

Configuration
REQ-023 With OV5640_INIT_RETRY_EN defined, wr_err SHALL re-issue the same entry up to 3 retries (4 attempts total); a 4th failure -> FAIL; the retry count SHALL reset on each advance.
REQ-024 Without OV5640_INIT_RETRY_EN, the first wr_err SHALL go to FAIL.

Structure
REQ-025 Package ov5640_init_pkg SHALL hold the state enum, the 24-bit entry field positions and the retry limit constant (3).
REQ-026 Sub-module ov5640_wait_timer (load value, start, expire pulse) SHALL implement both waits.

Verification
REQ-027 TABLE_LEN=4, PWR_WAIT_CYC=10, RST_WAIT_CYC=20, ack 3 cycles after each req, start -> 4 writes in table order; the write after idx 1 starts at least 20 cycles after the idx-1 ack; done = 1; busy = 0.
REQ-028 Entry 24'h3008_82 at idx 1 -> wr_addr = 16'h3008, wr_data = 8'h82, stable for the whole wr_req high.
REQ-029 wr_err on idx 2, macro undefined -> FAIL, err = 1, idx = 2, no further wr_req.
REQ-030 Macro defined, wr_err three times on idx 2 then wr_ack -> 4 attempts observed, sequence completes, done = 1; with four wr_err -> err = 1.
REQ-031 rst_n low during ISSUE at idx 1 -> wr_req = 0 immediately and all outputs at reset values; a new start then begins again at idx 0.
REQ-032 start pulsed while busy -> ignored, no idx change; start in DONE -> full rerun.
